// File: rtl/rx_corr_pkg.sv
// rx_corr_pkg: shared definitions for the rx correlation bank.
//   weight_e      ternary chip weight encoding (W_ZERO / W_POS / W_NEG)
//   clog2()       ceil(log2(v)), returns 0 for v <= 1
//   DEF_*_MASK    default chip template (period 10)
package rx_corr_pkg;

    typedef enum logic [1:0] {
        W_ZERO = 2'b00,
        W_POS  = 2'b01,
        W_NEG  = 2'b10
    } weight_e;

    localparam int unsigned DEF_MASK_W = 10;
    localparam logic [DEF_MASK_W-1:0] DEF_POS_MASK = 10'b1110000000;
    localparam logic [DEF_MASK_W-1:0] DEF_NEG_MASK = 10'b0000011100;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_corr_lane.sv
// rx_corr_lane: one correlator lane - applies the ternary weight to a sample,
// accumulates over the window and latches the final sum on the window's last trigger.
// Ports:
//   crx_clk, rrx_rst  clock, async active-high reset
//   erx_en            low clears the accumulator (result holds)
//   trig              new sample strobe
//   first / last      current trigger opens / closes the window
//   weight            weight_e encoding for the current phase
//   sample            signed lane sample
//   result            registered window sum
//   acc_next_c        [RX_CORR_PEAK_EN only] combinational next accumulator value
module rx_corr_lane import rx_corr_pkg::*; #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned RES_W    = 18
) (
    input  logic                       crx_clk,
    input  logic                       rrx_rst,
    input  logic                       erx_en,
    input  logic                       trig,
    input  logic                       first,
    input  logic                       last,
    input  logic [1:0]                 weight,
    input  logic signed [SAMPLE_W-1:0] sample,
`ifdef RX_CORR_PEAK_EN
    output logic signed [RES_W-1:0]    acc_next_c,
`endif
    output logic signed [RES_W-1:0]    result
);

    logic signed [RES_W-1:0] sext;
    logic signed [RES_W-1:0] term;
    logic signed [RES_W-1:0] acc;
    logic signed [RES_W-1:0] acc_next;

    // Widen before negating so the most negative sample negates exactly.
    assign sext = RES_W'(sample);

    always_comb begin
        term = '0;
        if (weight == W_POS) begin
            term = sext;
        end else if (weight == W_NEG) begin
            term = -sext;
        end
        acc_next = (first ? '0 : acc) + term;
    end

`ifdef RX_CORR_PEAK_EN
    assign acc_next_c = acc_next;
`endif

    // Accumulator and window result register.
    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            acc    <= '0;
            result <= '0;
        end else if (!erx_en) begin
            acc <= '0;
        end else if (trig) begin
            acc <= acc_next;
            if (last) begin
                result <= acc_next;
            end
        end
    end

endmodule

// File: rtl/rx_correlation_bank.sv
// rx_correlation_bank: multi-lane ternary-template correlator.
// Applies a +1/0/-1 chip template indexed by a shared sample phase to LANES
// sample streams, sums ACC_SAMPLES weighted samples per lane and publishes one
// result per lane with a one-cycle ovalid pulse.
// Optional feature macro: RX_CORR_PEAK_EN (peak |result| lane search).
// Ports:
//   crx_clk, rrx_rst    clock, async active-high reset
//   erx_en              enable; low discards the partial window
//   inew_sample_trig    new sample set strobe
//   isync               reload phase to its reset value
//   isamples            LANES x SAMPLE_W signed samples
//   oresults            LANES x RES_W signed results
//   ovalid              one-cycle result strobe
//   opeak_idx/opeak_mag [RX_CORR_PEAK_EN only] lane and magnitude of max |result|
module rx_correlation_bank import rx_corr_pkg::*; #(
    parameter int unsigned SAMPLE_W        = 16,
    parameter int unsigned LANES           = 2,
    parameter int unsigned PERIOD          = 10,
    parameter int unsigned SAMPLE_POSITION = 0,
    parameter int unsigned ACC_SAMPLES     = 2,
    parameter int unsigned MASK_W          = DEF_MASK_W,
    parameter logic [MASK_W-1:0] POS_MASK  = DEF_POS_MASK,
    parameter logic [MASK_W-1:0] NEG_MASK  = DEF_NEG_MASK,
    localparam int unsigned RES_W = SAMPLE_W + 1 + clog2(ACC_SAMPLES),
    localparam int unsigned IDX_W = (LANES > 1) ? clog2(LANES) : 1
) (
    input  logic                      crx_clk,
    input  logic                      rrx_rst,
    input  logic                      erx_en,
    input  logic                      inew_sample_trig,
    input  logic                      isync,
    input  logic [LANES*SAMPLE_W-1:0] isamples,
    output logic [LANES*RES_W-1:0]    oresults,
    output logic                      ovalid
`ifdef RX_CORR_PEAK_EN
    ,
    output logic [IDX_W-1:0]          opeak_idx,
    output logic [RES_W-1:0]          opeak_mag
`endif
);

    localparam int unsigned PHASE_W = (PERIOD > 1) ? clog2(PERIOD) : 1;
    localparam int unsigned CNT_W   = (ACC_SAMPLES > 1) ? clog2(ACC_SAMPLES) : 1;
    localparam logic [PHASE_W-1:0] RST_PHASE =
        PHASE_W'((PERIOD - (SAMPLE_POSITION % PERIOD)) % PERIOD);

    if ((POS_MASK & NEG_MASK) != '0) begin : g_err_overlap
        $error("rx_correlation_bank: POS_MASK and NEG_MASK overlap");
    end
    if (PERIOD > MASK_W) begin : g_err_period
        $error("rx_correlation_bank: PERIOD exceeds template mask width");
    end
    if (ACC_SAMPLES < 1) begin : g_err_acc
        $error("rx_correlation_bank: ACC_SAMPLES must be >= 1");
    end

    logic [PHASE_W-1:0] phase;
    logic [CNT_W-1:0]   acc_cnt;
    logic [MASK_W-1:0]  phase_oh;
    weight_e            weight;
    logic               first_c;
    logic               last_c;

    assign first_c = (acc_cnt == '0);
    assign last_c  = (acc_cnt == CNT_W'(ACC_SAMPLES - 1));

    // Weight decode for the current phase.
    always_comb begin
        phase_oh = MASK_W'(1) << phase;
        weight   = W_ZERO;
        if ((POS_MASK & phase_oh) != '0) begin
            weight = W_POS;
        end else if ((NEG_MASK & phase_oh) != '0) begin
            weight = W_NEG;
        end
    end

    // Phase tracks triggers regardless of erx_en so alignment survives a disable.
    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            phase   <= RST_PHASE;
            acc_cnt <= '0;
            ovalid  <= 1'b0;
        end else begin
            if (isync) begin
                phase <= RST_PHASE;
            end else if (inew_sample_trig) begin
                phase <= (phase == PHASE_W'(PERIOD - 1)) ? '0 : phase + PHASE_W'(1);
            end

            if (!erx_en) begin
                acc_cnt <= '0;
                ovalid  <= 1'b0;
            end else if (inew_sample_trig) begin
                acc_cnt <= last_c ? '0 : acc_cnt + CNT_W'(1);
                ovalid  <= last_c;
            end else begin
                ovalid <= 1'b0;
            end
        end
    end

`ifdef RX_CORR_PEAK_EN
    logic signed [RES_W-1:0] lane_next [LANES];
`endif

    for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
        rx_corr_lane #(
            .SAMPLE_W (SAMPLE_W),
            .RES_W    (RES_W)
        ) u_lane (
            .crx_clk    (crx_clk),
            .rrx_rst    (rrx_rst),
            .erx_en     (erx_en),
            .trig       (inew_sample_trig),
            .first      (first_c),
            .last       (last_c),
            .weight     (weight),
            .sample     (isamples[k*SAMPLE_W +: SAMPLE_W]),
`ifdef RX_CORR_PEAK_EN
            .acc_next_c (lane_next[k]),
`endif
            .result     (oresults[k*RES_W +: RES_W])
        );
    end

`ifdef RX_CORR_PEAK_EN
    logic [IDX_W-1:0] best_idx;
    logic [RES_W-1:0] best_mag;
    logic [RES_W-1:0] mag;

    // Max |final sum| across lanes; strict compare keeps the lowest lane on ties.
    always_comb begin
        best_idx = '0;
        best_mag = '0;
        mag      = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            mag = lane_next[k][RES_W-1] ? RES_W'(-lane_next[k]) : RES_W'(lane_next[k]);
            if (mag > best_mag) begin
                best_mag = mag;
                best_idx = IDX_W'(k);
            end
        end
    end

    // Published on the same edge as oresults.
    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            opeak_idx <= '0;
            opeak_mag <= '0;
        end else if (erx_en && inew_sample_trig && last_c) begin
            opeak_idx <= best_idx;
            opeak_mag <= best_mag;
        end
    end
`endif

endmodule

// File: tb/tb_rx_correlation_bank.sv
// Bench for rx_correlation_bank: directed window cases plus randomized traffic,
// checked against an arithmetic reference model of the correlator rules.
// Two instances run in lockstep: SAMPLE_POSITION=0 and SAMPLE_POSITION=3.
module tb_rx_correlation_bank;

    localparam int SAMPLE_W = 16;
    localparam int LANES    = 2;
    localparam int PERIOD   = 10;
    localparam int ACC      = 2;
    localparam int RES_W    = 18;
    localparam int NDUT     = 2;
    localparam logic [9:0] POS_M = 10'b1110000000;
    localparam logic [9:0] NEG_M = 10'b0000011100;

    logic                      crx_clk = 1'b0;
    logic                      rrx_rst;
    logic                      erx_en;
    logic                      inew_sample_trig;
    logic                      isync;
    logic [LANES*SAMPLE_W-1:0] isamples;
    logic [LANES*RES_W-1:0]    res0, res1;
    logic                      valid0, valid1;
`ifdef RX_CORR_PEAK_EN
    logic                      pidx0, pidx1;
    logic [RES_W-1:0]          pmag0, pmag1;
`endif

    always #5 crx_clk = ~crx_clk;

    rx_correlation_bank u_dut (
        .crx_clk          (crx_clk),
        .rrx_rst          (rrx_rst),
        .erx_en           (erx_en),
        .inew_sample_trig (inew_sample_trig),
        .isync            (isync),
        .isamples         (isamples),
        .oresults         (res0),
        .ovalid           (valid0)
`ifdef RX_CORR_PEAK_EN
        ,
        .opeak_idx        (pidx0),
        .opeak_mag        (pmag0)
`endif
    );

    rx_correlation_bank #(.SAMPLE_POSITION(3)) u_dut_sp3 (
        .crx_clk          (crx_clk),
        .rrx_rst          (rrx_rst),
        .erx_en           (erx_en),
        .inew_sample_trig (inew_sample_trig),
        .isync            (isync),
        .isamples         (isamples),
        .oresults         (res1),
        .ovalid           (valid1)
`ifdef RX_CORR_PEAK_EN
        ,
        .opeak_idx        (pidx1),
        .opeak_mag        (pmag1)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model state
    int     m_rst_phase [NDUT] = '{0, 7};
    int     m_phase [NDUT];
    int     m_cnt   [NDUT];
    longint m_acc   [NDUT][LANES];
    longint m_res   [NDUT][LANES];
    bit     m_valid [NDUT];
    longint m_pidx  [NDUT];
    longint m_pmag  [NDUT];

    function automatic longint dut_res(input int d, input int k);
        logic [RES_W-1:0] v;
        v = (d == 0) ? res0[k*RES_W +: RES_W] : res1[k*RES_W +: RES_W];
        return longint'($signed(v));
    endfunction

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            m_phase[d] = m_rst_phase[d];
            m_cnt[d]   = 0;
            m_valid[d] = 1'b0;
            m_pidx[d]  = 0;
            m_pmag[d]  = 0;
            for (int k = 0; k < LANES; k++) begin
                m_acc[d][k] = 0;
                m_res[d][k] = 0;
            end
        end
    endtask

    task automatic model_step(input bit en, input bit tr, input bit sy, input int s0, input int s1);
        int     w;
        longint s [LANES];
        longint a;
        s[0] = s0;
        s[1] = s1;
        for (int d = 0; d < NDUT; d++) begin
            m_valid[d] = 1'b0;
            if (!en) begin
                m_cnt[d] = 0;
                for (int k = 0; k < LANES; k++) m_acc[d][k] = 0;
            end else if (tr) begin
                w = POS_M[m_phase[d]] ? 1 : (NEG_M[m_phase[d]] ? -1 : 0);
                for (int k = 0; k < LANES; k++)
                    m_acc[d][k] = ((m_cnt[d] == 0) ? 0 : m_acc[d][k]) + w * s[k];
                if (m_cnt[d] == ACC - 1) begin
                    m_valid[d] = 1'b1;
                    m_cnt[d]   = 0;
                    m_pidx[d]  = 0;
                    m_pmag[d]  = 0;
                    for (int k = 0; k < LANES; k++) begin
                        m_res[d][k] = m_acc[d][k];
                        a = (m_acc[d][k] < 0) ? -m_acc[d][k] : m_acc[d][k];
                        if (a > m_pmag[d]) begin
                            m_pmag[d] = a;
                            m_pidx[d] = k;
                        end
                    end
                end else begin
                    m_cnt[d]++;
                end
            end
            if (sy) m_phase[d] = m_rst_phase[d];
            else if (tr) m_phase[d] = (m_phase[d] + 1) % PERIOD;
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < NDUT; d++) begin
            check_val($sformatf("d%0d_valid", d), longint'((d == 0) ? valid0 : valid1),
                      longint'(m_valid[d]));
            for (int k = 0; k < LANES; k++)
                check_val($sformatf("d%0d_res%0d", d, k), dut_res(d, k), m_res[d][k]);
`ifdef RX_CORR_PEAK_EN
            check_val($sformatf("d%0d_pidx", d), longint'((d == 0) ? pidx0 : pidx1), m_pidx[d]);
            check_val($sformatf("d%0d_pmag", d), longint'((d == 0) ? pmag0 : pmag1), m_pmag[d]);
`endif
        end
    endtask

    task automatic step(input bit en, input bit tr, input bit sy, input int s0, input int s1);
        erx_en           = en;
        inew_sample_trig = tr;
        isync            = sy;
        isamples[0*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(s0);
        isamples[1*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(s1);
        @(posedge crx_clk);
        #1;
        model_step(en, tr, sy, s0, s1);
        check_all();
    endtask

    task automatic do_reset();
        rrx_rst          = 1'b1;
        erx_en           = 1'b0;
        inew_sample_trig = 1'b0;
        isync            = 1'b0;
        isamples         = '0;
        repeat (2) @(posedge crx_clk);
        #1;
        model_reset();
        check_all();
        rrx_rst = 1'b0;
    endtask

    function automatic int rand_sample();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return -32768;
        if (r == 1) return 32767;
        return int'($signed(16'($urandom)));
    endfunction

    initial begin
        rrx_rst = 1'b1;

        // Constant samples, trigger every clock
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b1, 1'b0, 100, -50);
            if (i == 2) begin
                check_val("s1_ph01_l0", dut_res(0, 0), 0);
                check_val("s1_ph01_l1", dut_res(0, 1), 0);
                check_val("s5_sp3_l0", dut_res(1, 0), 200);
                check_val("s5_sp3_l1", dut_res(1, 1), -100);
            end
            if (i == 4) begin
                check_val("s1_ph23_l0", dut_res(0, 0), -200);
                check_val("s1_ph23_l1", dut_res(0, 1), 100);
            end
            if (i == 10) begin
                check_val("s1_ph89_l0", dut_res(0, 0), 200);
                check_val("s1_ph89_l1", dut_res(0, 1), -100);
            end
        end

        // Most negative sample negated at the -1 phases
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 1'b0, -32768, 0);
        check_val("s2_minneg_valid", longint'(valid0), 1);
        check_val("s2_minneg_res", dut_res(0, 0), 65536);

        // Disable mid-window discards the partial sum
        do_reset();
        step(1'b1, 1'b1, 1'b0, 9, 9);
        step(1'b0, 1'b0, 1'b0, 9, 9);
        check_val("s3_drop_valid", longint'(valid0), 0);
        step(1'b1, 1'b1, 1'b0, 7, 7);
        check_val("s3_restart_novalid", longint'(valid0), 0);
        step(1'b1, 1'b1, 1'b0, 7, 7);
        check_val("s3_restart_valid", longint'(valid0), 1);
        check_val("s3_restart_res", dut_res(0, 0), -7);

        // isync coincident with trigger at phase 6
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 100, 100);
        step(1'b1, 1'b1, 1'b1, 100, 100);
        step(1'b1, 1'b1, 1'b0, 100, 100);
        step(1'b1, 1'b1, 1'b0, 100, 100);
        step(1'b1, 1'b1, 1'b0, 100, 100);
        check_val("s4_realign_res", dut_res(0, 0), -100);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 19) != 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 29) == 0, rand_sample(), rand_sample());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
